ps2_device_emulator: RTL

- Device side of the PS/2 link: generates the PS/2 clock and acts as a bus-level mouse/keyboard model.
- Sends bytes to the host (device-to-host frames).
- Detects host request-to-send, clocks in host-to-device commands and drives the line-level ACK bit.
- Used as a loopback partner for the mouse-init host logic on the board and as a synthesizable bench model.

---
 rtl/ps2_device_emulator.sv | 106 ++++++++++
 1 files changed

// File: rtl/ps2_device_emulator.sv
// ps2_device_emulator: device side of a PS/2 link that generates the clock, sends bytes to the host and receives host commands.
// Ports: clk/rst (sync, active-high); ps2_clk_in/ps2_data_in raw line samples;
// ps2_clk_oe/ps2_data_oe open-drain pull-low enables; tx_data/tx_valid/tx_ready byte
// handshake toward the host; tx_done/tx_abort frame result pulses; rx_data/rx_valid/
// rx_parity_err received command; rx_frame_err bad stop bit; busy/debug_state status.
module ps2_device_emulator #(
  parameter int HALF_PERIOD = 338,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_abort,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       busy,
  output logic [3:0] debug_state
);
  typedef enum logic [3:0] {
    IDLE, TX_HI, TX_LO, TX_STOP, INHIBIT, RX_WAIT, RX_LO, RX_HI, ACK_HI, ACK_LO, ACK_END
  } state_t;
  state_t state, state_n;
  logic [1:0] clk_sync, data_sync;
  logic clk_s, data_s, timed, expire;
  logic [CNT_W-1:0] cnt;
  logic [3:0] idx;
  logic [10:0] frame;
  logic [8:0] rx_bits;
  assign clk_s = clk_sync[1];
  assign data_s = data_sync[1];
  assign timed = !(state inside {IDLE, INHIBIT});
  assign expire = cnt == CNT_W'(HALF_PERIOD - 1);
  // Synchronizers reset to the idle-bus level so reset does not fake a host inhibit.
  always_ff @(posedge clk) begin
    clk_sync <= rst ? 2'b11 : {clk_sync[0], ps2_clk_in};
    data_sync <= rst ? 2'b11 : {data_sync[0], ps2_data_in};
    cnt <= (rst || !timed || expire) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // Every timed state leaves at expiry, so the phase timer restarts on each entry.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !clk_s ? INHIBIT : (tx_valid && tx_ready) ? TX_HI : IDLE;
      TX_HI:   state_n = !expire ? TX_HI : clk_s ? TX_LO : INHIBIT;
      TX_LO:   state_n = !expire ? TX_LO : (idx == 4'd10) ? TX_STOP : TX_HI;
      TX_STOP: state_n = expire ? IDLE : TX_STOP;
      INHIBIT: state_n = !clk_s ? INHIBIT : data_s ? IDLE : RX_WAIT;
      RX_WAIT: state_n = expire ? RX_LO : RX_WAIT;
      RX_LO:   state_n = expire ? RX_HI : RX_LO;
      RX_HI:   state_n = !expire ? RX_HI : !clk_s ? INHIBIT :
                         (idx != 4'd9) ? RX_LO : data_s ? ACK_HI : IDLE;
      ACK_HI:  state_n = expire ? ACK_LO : ACK_HI;
      ACK_LO:  state_n = expire ? ACK_END : ACK_LO;
      ACK_END: state_n = expire ? IDLE : ACK_END;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    tx_ready = state == IDLE && clk_s && data_s && !rst;
    ps2_clk_oe = state inside {TX_LO, RX_LO, ACK_LO};
    ps2_data_oe = (state inside {TX_HI, TX_LO}) ? !frame[idx] : (state inside {ACK_HI, ACK_LO});
    busy = state != IDLE;
    debug_state = state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      frame <= '0;
      rx_bits <= '0;
      rx_data <= '0;
      rx_parity_err <= 1'b0;
      tx_done <= 1'b0;
      tx_abort <= 1'b0;
      rx_valid <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      tx_done <= state == TX_STOP && expire;
      tx_abort <= state == TX_HI && expire && !clk_s;
      rx_valid <= state == ACK_END && expire;
      rx_frame_err <= state == RX_HI && expire && clk_s && idx == 4'd9 && !data_s;
      if (state == IDLE && tx_valid && tx_ready)
        frame <= {1'b1, ~^tx_data, tx_data, 1'b0};
      if (state inside {IDLE, RX_WAIT})
        idx <= '0;
      else if (expire && ((state == TX_LO && idx != 4'd10) || (state == RX_HI && clk_s)))
        idx <= idx + 1'b1;
      // Data and parity shift in LSB first; the stop bit is judged live and never stored.
      if (state == RX_HI && expire && clk_s && idx < 4'd9)
        rx_bits <= {data_s, rx_bits[8:1]};
      if (state == ACK_END && expire) begin
        rx_data <= rx_bits[7:0];
        rx_parity_err <= rx_bits[8] == ^rx_bits[7:0];
      end
    end
  end
endmodule
